// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC calibration sequencer.
package tdc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SET,
      ST_SETTLE,
      ST_ACCUM,
      ST_EVAL,
      ST_DONE
   } cal_state_t;

   typedef logic signed [3:0] tdc_code_t;

   localparam tdc_code_t TDC_CODE_MIN = 4'sb1000;  // -8
   localparam tdc_code_t TDC_CODE_MAX = 4'sb0111;  // +7

   // A code at either end of the range means the delay line ran out of phases.
   function automatic logic is_sat(input tdc_code_t c);
      return (c == TDC_CODE_MIN) || (c == TDC_CODE_MAX);
   endfunction

endpackage

// File: rtl/tdc_cal_accum.sv
// Signed sample accumulator for one SAR step: sums 2^N_AVG_LOG2 valid
// samples, then raises done and ignores further samples until cleared.
module tdc_cal_accum
   import tdc_pkg::*;
#(
   parameter int N_AVG_LOG2 = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clear,
   input  logic                        enable,
   input  logic signed [3:0]           sample,
   input  logic                        valid,
   output logic signed [3+N_AVG_LOG2:0] sum,
   output logic                        done
);

   localparam int ACC_W = 4 + N_AVG_LOG2;
   localparam int CNT_W = N_AVG_LOG2 + 1;

   logic signed [ACC_W-1:0] sum_q, sum_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   tdc_code_t               sample_c;

   assign sample_c = sample;
   // The counter stops at exactly 2^N_AVG_LOG2, so its MSB is the done flag.
   assign done     = cnt_q[CNT_W-1];
   assign sum      = sum_q;

   // Next-state: clear wins, otherwise add one sign-extended sample per strobe.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      sum_d = sum_q;
      cnt_d = cnt_q;
      if (clear) begin
         sum_d = '0;
         cnt_d = '0;
      end else if (enable && valid && !done) begin
         sum_d = sum_q + ACC_W'(sample_c);
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Accumulator and sample-counter registers.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         sum_q <= '0;
         cnt_q <= '0;
      end else begin
         sum_q <= sum_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tdc_cal_ctrl.sv
// TDC calibration sequencer: SAR search on the reference-delay trim code
// driving the mean TDC output toward zero, plus the registered code path
// to the loop filter. Optional feature macro: TDC_CAL_SATCNT_EN adds the
// sat_cnt output counting saturated samples accumulated during calibration.
module tdc_cal_ctrl
   import tdc_pkg::*;
#(
   parameter int                TRIM_W     = 5,
   parameter logic [TRIM_W-1:0] TRIM_INIT  = 5'b10000,
   parameter int                N_AVG_LOG2 = 4,
   parameter int                SETTLE_N   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cal_start,
   input  logic signed [3:0] tdc_out,
   input  logic              tdc_valid,
   output logic [TRIM_W-1:0] trim,
   output logic              cal_busy,
   output logic              cal_done,
   output logic signed [3:0] code_out,
   output logic              code_valid,
`ifdef TDC_CAL_SATCNT_EN
   output logic [7:0]        sat_cnt,
`endif
   output logic              sat
);

   localparam int ACC_W = 4 + N_AVG_LOG2;
   localparam int BIT_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
   localparam int SET_W = $clog2(SETTLE_N + 1);
   localparam logic [BIT_W-1:0] BIT_MSB   = BIT_W'(TRIM_W - 1);
   localparam logic [SET_W-1:0] SET_LAST  = SET_W'(SETTLE_N - 1);

   cal_state_t        state_q, state_d;
   logic [TRIM_W-1:0] trim_q, trim_d;
   logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
   logic [SET_W-1:0]  settle_q, settle_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic signed [3:0] code_q;
   logic              code_valid_q;
   logic              sat_q;

   logic                    acc_clear;
   logic                    acc_en;
   logic signed [ACC_W-1:0] acc_sum;
   logic                    acc_done;

   tdc_cal_accum #(
      .N_AVG_LOG2 (N_AVG_LOG2)
   ) u_accum (
      .clk    (clk),
      .rst    (rst),
      .clear  (acc_clear),
      .enable (acc_en),
      .sample (tdc_out),
      .valid  (tdc_valid),
      .sum    (acc_sum),
      .done   (acc_done)
   );

   // SAR sequencer: next state, trim bit trial/decision, busy/done flags.
   always_comb begin
      state_d   = state_q;
      trim_d    = trim_q;
      bit_idx_d = bit_idx_q;
      settle_d  = settle_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      acc_clear = 1'b0;
      acc_en    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cal_start) begin
               state_d   = ST_SET;
               bit_idx_d = BIT_MSB;
               trim_d    = '0;
               busy_d    = 1'b1;
            end
         end
         ST_SET: begin
            trim_d[bit_idx_q] = 1'b1;
            settle_d          = '0;
            acc_clear         = 1'b1;
            state_d           = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (tdc_valid) begin
               if (settle_q == SET_LAST) state_d = ST_ACCUM;
               else                      settle_d = settle_q + SET_W'(1);
            end
         end
         ST_ACCUM: begin
            acc_en = 1'b1;
            if (acc_done) state_d = ST_EVAL;
         end
         ST_EVAL: begin
            // Larger trim lowers the mean code: a negative sum means overshoot.
            if (acc_sum[ACC_W-1]) trim_d[bit_idx_q] = 1'b0;
            if (bit_idx_q == '0) begin
               state_d = ST_DONE;
            end else begin
               bit_idx_d = bit_idx_q - BIT_W'(1);
               state_d   = ST_SET;
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sequencer state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         trim_q    <= TRIM_INIT;
         bit_idx_q <= '0;
         settle_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         trim_q    <= trim_d;
         bit_idx_q <= bit_idx_d;
         settle_q  <= settle_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Code path: capture each valid code; gate the strobe with next-cycle busy
   // so code_valid and cal_busy are never high together.
   always_ff @(posedge clk) begin
      if (rst) begin
         code_q       <= '0;
         code_valid_q <= 1'b0;
         sat_q        <= 1'b0;
      end else begin
         code_valid_q <= tdc_valid && !busy_d;
         if (tdc_valid) begin
            code_q <= tdc_out;
            sat_q  <= is_sat(tdc_out);
         end
      end
   end

`ifdef TDC_CAL_SATCNT_EN
   logic [7:0] sat_cnt_q, sat_cnt_d;

   // Saturated-sample counter: cleared at the MSB trial, counts only samples
   // the accumulator actually takes, sticks at 255.
   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (state_q == ST_SET && bit_idx_q == BIT_MSB) begin
         sat_cnt_d = '0;
      end else if (state_q == ST_ACCUM && tdc_valid && !acc_done &&
                   is_sat(tdc_out) && sat_cnt_q != 8'hFF) begin
         sat_cnt_d = sat_cnt_q + 8'd1;
      end
   end

   // Saturated-sample counter register.
   always_ff @(posedge clk) begin
      if (rst) sat_cnt_q <= '0;
      else     sat_cnt_q <= sat_cnt_d;
   end

   assign sat_cnt = sat_cnt_q;
`endif

   assign trim       = trim_q;
   assign cal_busy   = busy_q;
   assign cal_done   = done_q;
   assign code_out   = code_q;
   assign code_valid = code_valid_q;
   assign sat        = sat_q;

endmodule

// File: tb/tb_tdc_cal_ctrl.sv
// Self-checking bench for tdc_cal_ctrl. A TDC stand-in returns a code that
// depends only on the current trim (from a lookup table), so the expected
// SAR result follows directly from the table regardless of strobe timing.
module tb_tdc_cal_ctrl;

   logic              clk = 1'b0;
   logic              rst;
   logic              cal_start;
   logic signed [3:0] tdc_out;
   logic              tdc_valid;
   logic [4:0]        trim;
   logic              cal_busy;
   logic              cal_done;
   logic signed [3:0] code_out;
   logic              code_valid;
   logic              sat;
`ifdef TDC_CAL_SATCNT_EN
   logic [7:0]        sat_cnt;
`endif

   int n_pass  = 0;
   int n_total = 0;

   logic signed [3:0] f_tab [32];

   typedef struct {
      int         mode;      // 0: constant code, 1: clamp(12 - trim)
      int         value;
      logic [4:0] exp_trim;
      bit         chk_sat;
      bit         exp_sat;
      int         exp_satcnt;
   } vec_t;

   vec_t vecs [6];

   always #5 clk = ~clk;

   tdc_cal_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .cal_start  (cal_start),
      .tdc_out    (tdc_out),
      .tdc_valid  (tdc_valid),
      .trim       (trim),
      .cal_busy   (cal_busy),
      .cal_done   (cal_done),
      .code_out   (code_out),
      .code_valid (code_valid),
`ifdef TDC_CAL_SATCNT_EN
      .sat_cnt    (sat_cnt),
`endif
      .sat        (sat)
   );

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic bit code_is_sat(input int c);
      return (c == -8) || (c == 7);
   endfunction

   function automatic void load_tab(input int mode, input int value);
      for (int t = 0; t < 32; t++) begin
         int c;
         c = (mode == 1) ? 12 - t : value;
         if (c > 7)  c = 7;
         if (c < -8) c = -8;
         f_tab[t] = 4'(c);
      end
   endfunction

   // Reference SAR: try each bit MSB first; 16 identical samples per trial,
   // so the bit stays exactly when the trial code is >= 0.
   function automatic void ref_sar(output logic [4:0] t, output int nsat);
      logic [4:0] c;
      t    = '0;
      nsat = 0;
      for (int b = 4; b >= 0; b--) begin
         c = t | (5'd1 << b);
         if (code_is_sat(int'(f_tab[c]))) nsat += 16;
         if (int'(f_tab[c]) >= 0) t = c;
      end
   endfunction

   // mode 0: single start pulse, 1: extra pulse mid-run, 2: start held high
   task automatic run_cal(input int mode, output int pulses, output bit busy_ok,
                          output bit cv_ok, output bit to);
      pulses  = 0;
      busy_ok = 1'b1;
      cv_ok   = 1'b1;
      to      = 1'b1;
      @(negedge clk);
      cal_start = 1'b1;
      tdc_valid = 1'b0;
      for (int cyc = 0; cyc < 5000; cyc++) begin
         @(negedge clk);
         if (cal_done) begin
            pulses++;
            if (cal_busy) busy_ok = 1'b0;
            cal_start = 1'b0;
            tdc_valid = 1'b0;
            to        = 1'b0;
            break;
         end
         if (!cal_busy)  busy_ok = 1'b0;
         if (code_valid) cv_ok   = 1'b0;
         cal_start = (mode == 2) || (mode == 1 && cyc == 50);
         tdc_valid = 1'($urandom_range(0, 1));
         tdc_out   = f_tab[trim];
      end
      cal_start = 1'b0;
      tdc_valid = 1'b0;
   endtask

   task automatic cal_and_check(input string tag, input int mode,
                                input logic [4:0] exp_trim, input int exp_satcnt);
      int pulses;
      bit busy_ok, cv_ok, to;
      run_cal(mode, pulses, busy_ok, cv_ok, to);
      check({tag, "_timeout"}, int'(to), 0);
      check({tag, "_done_pulses"}, pulses, 1);
      check({tag, "_busy_whole_run"}, int'(busy_ok), 1);
      check({tag, "_no_code_valid_busy"}, int'(cv_ok), 1);
      check({tag, "_trim"}, int'(trim), int'(exp_trim));
`ifdef TDC_CAL_SATCNT_EN
      check({tag, "_sat_cnt"}, int'(sat_cnt), exp_satcnt);
`else
      if (exp_satcnt < 0) $display("unexpected sat count %0d", exp_satcnt);
`endif
      @(negedge clk);
      check({tag, "_idle_after"}, int'({cal_busy, cal_done}), 0);
   endtask

   initial begin
      logic [4:0] exp_t;
      int         exp_n;
      int         exp_code;
      bit         exp_sat;
      int         c;
      bit         v;
      int         late_done;

      rst       = 1'b1;
      cal_start = 1'b0;
      tdc_valid = 1'b0;
      tdc_out   = '0;
      repeat (3) @(negedge clk);
      check("rst_trim", int'(trim), 16);
      check("rst_busy", int'(cal_busy), 0);
      check("rst_done", int'(cal_done), 0);
      check("rst_code_out", int'(code_out), 0);
      check("rst_code_valid", int'(code_valid), 0);
      check("rst_sat", int'(sat), 0);
`ifdef TDC_CAL_SATCNT_EN
      check("rst_sat_cnt", int'(sat_cnt), 0);
`endif
      rst = 1'b0;
      @(negedge clk);

      // Passthrough in IDLE, one-cycle latency.
      tdc_valid = 1'b1; tdc_out = 4'sd3;
      @(negedge clk);
      check("pass_code", int'(code_out), 3);
      check("pass_valid", int'(code_valid), 1);
      check("pass_sat", int'(sat), 0);
      tdc_valid = 1'b0; tdc_out = -4'sd5;
      @(negedge clk);
      check("pass_valid_drop", int'(code_valid), 0);
      check("pass_code_hold", int'(code_out), 3);

      // Random passthrough against last-valid model.
      exp_code = 3;
      exp_sat  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         c = $urandom_range(0, 15) - 8;
         v = 1'($urandom_range(0, 1));
         tdc_out   = 4'(c);
         tdc_valid = v;
         if (v) begin
            exp_code = c;
            exp_sat  = code_is_sat(c);
         end
         @(negedge clk);
         check("rnd_pass_valid", int'(code_valid), int'(v));
         check("rnd_pass_code", int'(code_out), exp_code);
         check("rnd_pass_sat", int'(sat), int'(exp_sat));
      end
      tdc_valid = 1'b0;
      @(negedge clk);

      // Table of directed calibration runs.
      vecs[0] = '{1, 0,  5'd12,    1'b0, 1'b0, 0};
      vecs[1] = '{0, 7,  5'b11111, 1'b1, 1'b1, 80};
      vecs[2] = '{0, -8, 5'b00000, 1'b1, 1'b1, 80};
      vecs[3] = '{0, 0,  5'b11111, 1'b1, 1'b0, 0};
      vecs[4] = '{0, -1, 5'b00000, 1'b1, 1'b0, 0};
      vecs[5] = '{0, 3,  5'b11111, 1'b1, 1'b0, 0};
      for (int i = 0; i < 6; i++) begin
         load_tab(vecs[i].mode, vecs[i].value);
         cal_and_check($sformatf("vec%0d", i), 0, vecs[i].exp_trim, vecs[i].exp_satcnt);
         if (vecs[i].chk_sat) check($sformatf("vec%0d_sat", i), int'(sat), int'(vecs[i].exp_sat));
      end

      // Second start mid-run, and start held through DONE: both ignored.
      load_tab(1, 0);
      cal_and_check("restart_mid", 1, 5'd12, 0);
      cal_and_check("start_held", 2, 5'd12, 0);

      // Random trim-to-code tables checked against the reference SAR.
      for (int k = 0; k < 4; k++) begin
         for (int t = 0; t < 32; t++) f_tab[t] = 4'($urandom_range(0, 15));
         ref_sar(exp_t, exp_n);
         cal_and_check($sformatf("rnd%0d", k), 0, exp_t, exp_n);
      end

      // Reset in the middle of the second step's accumulation.
      load_tab(0, 7);
      @(negedge clk);
      cal_start = 1'b1; tdc_valid = 1'b1; tdc_out = 4'sd7;
      @(negedge clk);
      cal_start = 1'b0;
      repeat (44) @(negedge clk);
      check("mid_trim", int'(trim), 24);
      check("mid_busy", int'(cal_busy), 1);
      rst = 1'b1; tdc_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("mrst_trim", int'(trim), 16);
      check("mrst_busy", int'(cal_busy), 0);
      check("mrst_done", int'(cal_done), 0);
      check("mrst_code_valid", int'(code_valid), 0);
      late_done = 0;
      repeat (10) begin
         @(negedge clk);
         if (cal_done || cal_busy) late_done++;
      end
      check("mrst_stays_idle", late_done, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
